// File: rtl/ca_keystream_gen.sv
// rtl/ca_keystream_gen.sv - per-cell-rule cellular automaton keystream generator
module ca_keystream_gen #(
  parameter int N      = 32,
  parameter int WARMUP = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           seed_valid,
  output logic           seed_ready,
  input  logic [N-1:0]   seed_data,
  input  logic [3*N-1:0] rule_cfg,
  output logic           ks_valid,
  input  logic           ks_ready,
  output logic [N-1:0]   ks_data,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } fsm_e;

  localparam logic [9:0] WARM_LAST = 10'(WARMUP - 1);

  fsm_e           fsm_q, fsm_d;
  logic [N-1:0]   cells_q, cells_d;
  logic [3*N-1:0] rule_q, rule_d;
  logic [9:0]     cnt_q, cnt_d;
  logic [N-1:0]   step_w;
  logic [N-1:0]   seed_fix;
  logic [N+1:0]   pad_w;

  // Zero pad on both ends gives the null boundary: cell i sees pad[i], pad[i+1], pad[i+2].
  assign pad_w    = {1'b0, cells_q, 1'b0};
  assign seed_fix = (seed_data == '0) ? N'(1) : seed_data;

  always_comb begin
    step_w = '0;
    for (int i = 0; i < N; i++) begin
      logic a, b, c;
      logic [2:0] code;
      b    = pad_w[i];
      a    = pad_w[i+1];
      c    = pad_w[i+2];
      code = rule_q[3*i +: 3];
      case (code)
        3'd1:    step_w[i] = a ^ b ^ c ^ (b & c);
        3'd2:    step_w[i] = a ^ b;
        3'd3:    step_w[i] = a ^ c;
        3'd4:    step_w[i] = a ^ (b & c);
        3'd5:    step_w[i] = a ^ b ^ c;
        3'd6:    step_w[i] = a ^ b ^ (b & c);
        3'd7:    step_w[i] = a ^ c ^ (b & c);
        default: step_w[i] = a;
      endcase
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    cells_d = cells_q;
    rule_d  = rule_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      IDLE: begin
        if (seed_valid) begin
          cells_d = seed_fix;
          rule_d  = rule_cfg;
          cnt_d   = '0;
          fsm_d   = WARM;
        end
      end
      WARM: begin
        cells_d = step_w;
        cnt_d   = cnt_q + 10'd1;
        if (cnt_q == WARM_LAST) fsm_d = RUN;
      end
      RUN: begin
        // A reseed wins over a consume; the presented word is not counted as taken.
        if (seed_valid) begin
          cells_d = seed_fix;
          rule_d  = rule_cfg;
          cnt_d   = '0;
          fsm_d   = WARM;
        end else if (ks_ready) begin
          cells_d = step_w;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cells_q <= '0;
      rule_q  <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cells_q <= cells_d;
      rule_q  <= rule_d;
      cnt_q   <= cnt_d;
    end
  end

  assign seed_ready = (fsm_q != WARM);
  assign ks_valid   = (fsm_q == RUN);
  assign busy       = (fsm_q == WARM);
  assign ks_data    = cells_q;

endmodule

// File: tb/tb_ca_keystream_gen.sv
// tb/tb_ca_keystream_gen.sv - directed checks of ca_keystream_gen across three parameter sets
module tb_ca_keystream_gen;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Instance A: N=32, WARMUP=4
  logic        sv_a, sr_a, kv_a, kr_a, bz_a;
  logic [31:0] sd_a, kd_a;
  logic [95:0] rc_a;
  // Instance B: N=32, WARMUP=1
  logic        sv_b, sr_b, kv_b, kr_b, bz_b;
  logic [31:0] sd_b, kd_b;
  logic [95:0] rc_b;
  // Instance C: N=8, WARMUP=1
  logic        sv_c, sr_c, kv_c, kr_c, bz_c;
  logic [7:0]  sd_c, kd_c;
  logic [23:0] rc_c;

  ca_keystream_gen #(.N(32), .WARMUP(4)) u_a (
    .clk(clk), .rst(rst), .seed_valid(sv_a), .seed_ready(sr_a), .seed_data(sd_a),
    .rule_cfg(rc_a), .ks_valid(kv_a), .ks_ready(kr_a), .ks_data(kd_a), .busy(bz_a));

  ca_keystream_gen #(.N(32), .WARMUP(1)) u_b (
    .clk(clk), .rst(rst), .seed_valid(sv_b), .seed_ready(sr_b), .seed_data(sd_b),
    .rule_cfg(rc_b), .ks_valid(kv_b), .ks_ready(kr_b), .ks_data(kd_b), .busy(bz_b));

  ca_keystream_gen #(.N(8), .WARMUP(1)) u_c (
    .clk(clk), .rst(rst), .seed_valid(sv_c), .seed_ready(sr_c), .seed_data(sd_c),
    .rule_cfg(rc_c), .ks_valid(kv_c), .ks_ready(kr_c), .ks_data(kd_c), .busy(bz_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    sv_a = 1'b0; sd_a = '0; rc_a = '0; kr_a = 1'b0;
    sv_b = 1'b0; sd_b = '0; rc_b = '0; kr_b = 1'b0;
    sv_c = 1'b0; sd_c = '0; rc_c = '0; kr_c = 1'b0;
    tick();
    check("reset_ks_valid",   kv_a, 0);
    check("reset_ks_data",    kd_a, 0);
    check("reset_busy",       bz_a, 0);
    check("reset_seed_ready", sr_a, 1);
    check("reset_c_ks_data",  kd_c, 0);
    rst = 1'b0;
    tick();
    check("idle_ks_valid", kv_a, 0);

    // Hold rule, WARMUP=4: valid appears after four warm steps
    sd_a = 32'hA5A5_A5A5; rc_a = '0; sv_a = 1'b1;
    tick();
    sv_a = 1'b0;
    check("warm_busy",       bz_a, 1);
    check("warm_seed_ready", sr_a, 0);
    check("warm_ks_valid",   kv_a, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("warm_still_invalid", kv_a, 0);
    end
    tick();
    check("hold_first_valid", kv_a, 1);
    check("hold_first_data",  kd_a, 32'hA5A5_A5A5);
    check("run_busy",         bz_a, 0);
    check("run_seed_ready",   sr_a, 1);
    // Rule input changes after seed accept must not take effect
    for (int i = 0; i < 32; i++) rc_a[3*i +: 3] = 3'd2;
    kr_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_accept_data",  kd_a, 32'hA5A5_A5A5);
      check("hold_accept_valid", kv_a, 1);
    end
    kr_a = 1'b0;

    // Code 2, WARMUP=1
    for (int i = 0; i < 32; i++) rc_b[3*i +: 3] = 3'd2;
    sd_b = 32'h0000_0001; sv_b = 1'b1;
    tick();
    sv_b = 1'b0;
    check("code2_warm_busy", bz_b, 1);
    tick();
    check("code2_valid", kv_b, 1);
    check("code2_word0", kd_b, 32'h0000_0003);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_data",  kd_b, 32'h0000_0003);
      check("bp_valid", kv_b, 1);
    end
    kr_b = 1'b1;
    tick();
    kr_b = 1'b0;
    check("code2_word1", kd_b, 32'h0000_0005);
    tick();
    check("code2_word1_hold", kd_b, 32'h0000_0005);
    kr_b = 1'b1;
    tick();
    kr_b = 1'b0;
    check("code2_word2", kd_b, 32'h0000_000F);

    // Seed beats consume in RUN
    sd_b = 32'h0000_0001; sv_b = 1'b1; kr_b = 1'b1;
    tick();
    sv_b = 1'b0; kr_b = 1'b0;
    check("prio_ks_valid", kv_b, 0);
    check("prio_busy",     bz_b, 1);
    check("prio_no_step",  kd_b, 32'h0000_0001);
    tick();
    check("prio_rerun_word", kd_b, 32'h0000_0003);

    // Zero seed is substituted by 1
    rc_b = '0; sd_b = '0; sv_b = 1'b1;
    tick();
    sv_b = 1'b0;
    tick();
    check("zero_seed_valid", kv_b, 1);
    check("zero_seed_data",  kd_b, 32'h0000_0001);

    // Reset in the middle of warm-up
    sd_a = 32'h1234_5678; rc_a = '0; sv_a = 1'b1;
    tick();
    sv_a = 1'b0;
    tick();
    check("midwarm_busy", bz_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_warm_ks_data",    kd_a, 0);
    check("rst_warm_seed_ready", sr_a, 1);
    check("rst_warm_busy",       bz_a, 0);
    for (int i = 0; i < 5; i++) tick();
    check("rst_warm_abandoned", kv_a, 0);

    // N=8 null boundary with code 5
    for (int i = 0; i < 8; i++) rc_c[3*i +: 3] = 3'd5;
    sd_c = 8'h80; sv_c = 1'b1;
    tick();
    sv_c = 1'b0;
    tick();
    check("boundary_word0", kd_c, 8'hC0);
    kr_c = 1'b1;
    tick();
    kr_c = 1'b0;
    check("boundary_word1", kd_c, 8'h20);

    // Mixed per-cell codes: cell i uses code i
    for (int i = 0; i < 8; i++) rc_c[3*i +: 3] = 3'(i);
    sd_c = 8'hFF; sv_c = 1'b1;
    tick();
    sv_c = 1'b0;
    tick();
    check("mixed_codes_fwd", kd_c, 8'hE1);
    // Cell i uses code 7-i
    for (int i = 0; i < 8; i++) rc_c[3*i +: 3] = 3'(7 - i);
    sv_c = 1'b1;
    tick();
    sv_c = 1'b0;
    tick();
    check("mixed_codes_rev", kd_c, 8'h86);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
